// File: rtl/r2_online_mult_seq.sv
// Radix-2 online (MSDF) serial multiplier: consumes one signed-digit pair per step and
// emits product digits most-significant first, DELTA steps behind the inputs.
module r2_online_mult_seq #(
    parameter int WIDTH = 8,
    parameter int DELTA = 3,
    parameter int GUARD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [1:0] x_d,
    input  logic [1:0] y_d,
    output logic       in_ready,
    output logic [1:0] p_d,
    output logic       out_valid,
    output logic       out_last,
    output logic       busy,
    output logic       err,
    output logic [1:0] dbg_state_o
);

    localparam int FRAC = WIDTH + DELTA + GUARD;
    localparam int RW   = FRAC + 2;
    localparam int OW   = WIDTH + 1;
    localparam int SW   = $clog2(WIDTH + DELTA + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [SW-1:0] S_WIDTH = SW'(WIDTH);
    localparam logic [SW-1:0] S_DELTA = SW'(DELTA);
    localparam logic [SW-1:0] S_LAST  = SW'(WIDTH + DELTA);

    localparam logic signed [RW-1:0] ONE   = RW'(1) << FRAC;
    localparam logic signed [RW-1:0] NONE  = -ONE;
    localparam logic signed [RW-1:0] HALF  = RW'(1) << (FRAC - 1);
    localparam logic signed [RW-1:0] NHALF = -HALF;
    localparam logic [OW-1:0]        MINUS_ONE = {1'b1, {WIDTH{1'b0}}};

    logic [1:0]           state_q, state_d;
    logic [SW-1:0]        s_q, s_d;
    logic signed [RW-1:0] w_q, w_d;
    // xq/yq hold the converted operand, xm/ym the same value minus one ulp of the current step.
    logic [OW-1:0]        xq_q, xq_d, xm_q, xm_d;
    logic [OW-1:0]        yq_q, yq_d, ym_q, ym_d;
    logic [1:0]           pdig_q, pdig_d;
    logic                 vld_q, vld_d;
    logic                 last_q, last_d;
    logic                 err_q, err_d;

    logic                 take, step, illegal;
    logic [1:0]           xdig, ydig;
    logic                 x_pos, x_neg, y_pos, y_neg;
    logic [SW-1:0]        s_nxt;
    logic [OW-1:0]        mask;
    logic [OW-1:0]        xq_nx, xm_nx, yq_nx, ym_nx;
    logic signed [RW-1:0] xe, ye, tx, ty, v, w_sel;
    logic [1:0]           p_sel;

    // Datapath for one step: digit decode, on-the-fly conversion, residual and selection.
    always_comb begin
        take    = (state_q == S_RUN) && in_valid;
        step    = take || ((state_q == S_FLUSH) && (s_q != S_LAST));
        illegal = take && ((x_d == 2'b10) || (y_d == 2'b10));
        xdig    = take ? x_d : 2'b00;
        ydig    = take ? y_d : 2'b00;
        x_pos   = (xdig == 2'b01);
        x_neg   = (xdig == 2'b11);
        y_pos   = (ydig == 2'b01);
        y_neg   = (ydig == 2'b11);
        s_nxt   = s_q + SW'(1);
        mask    = OW'(1) << (S_WIDTH - s_nxt);

        xq_nx = xq_q;
        xm_nx = xm_q;
        if (x_pos) begin
            xq_nx = xq_q | mask;
            xm_nx = xq_q;
        end else if (x_neg) begin
            xq_nx = xm_q | mask;
            xm_nx = xm_q;
        end else if (take) begin
            xm_nx = xm_q | mask;
        end

        yq_nx = yq_q;
        ym_nx = ym_q;
        if (y_pos) begin
            yq_nx = yq_q | mask;
            ym_nx = yq_q;
        end else if (y_neg) begin
            yq_nx = ym_q | mask;
            ym_nx = ym_q;
        end else if (take) begin
            ym_nx = ym_q | mask;
        end

        // X_{s-1}*y_s + Y_s*x_s, scaled by 2^-DELTA into the residual's fraction grid.
        xe = $signed({{(RW - OW){xq_q[OW-1]}}, xq_q}) <<< GUARD;
        ye = $signed({{(RW - OW){yq_nx[OW-1]}}, yq_nx}) <<< GUARD;
        tx = y_pos ? xe : (y_neg ? -xe : '0);
        ty = x_pos ? ye : (x_neg ? -ye : '0);
        v  = (w_q <<< 1) + tx + ty;

        p_sel = 2'b00;
        w_sel = v;
        if (s_nxt > S_DELTA) begin
            if (v >= HALF) begin
                p_sel = 2'b01;
                w_sel = v - ONE;
            end else if (v < NHALF) begin
                p_sel = 2'b11;
                w_sel = v + ONE;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        w_d     = w_q;
        xq_d    = xq_q;
        xm_d    = xm_q;
        yq_d    = yq_q;
        ym_d    = ym_q;
        pdig_d  = 2'b00;
        vld_d   = 1'b0;
        last_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    s_d     = '0;
                    w_d     = '0;
                    xq_d    = '0;
                    xm_d    = MINUS_ONE;
                    yq_d    = '0;
                    ym_d    = MINUS_ONE;
                    err_d   = 1'b0;
                end
            end
            S_RUN, S_FLUSH: begin
                if (step) begin
                    s_d  = s_nxt;
                    w_d  = w_sel;
                    xq_d = xq_nx;
                    xm_d = xm_nx;
                    yq_d = yq_nx;
                    ym_d = ym_nx;
                    if (s_nxt > S_DELTA) begin
                        pdig_d = p_sel;
                        vld_d  = 1'b1;
                        last_d = (s_nxt == S_LAST);
                    end
                end
                if (illegal) begin
                    err_d = 1'b1;
                end
                if ((state_q == S_RUN) && take && (s_nxt == S_WIDTH)) begin
                    state_d = S_FLUSH;
                end
                // All steps done: this cycle shows the last digit, then back to idle.
                if ((state_q == S_FLUSH) && (s_q == S_LAST)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            w_q     <= '0;
            xq_q    <= '0;
            xm_q    <= '0;
            yq_q    <= '0;
            ym_q    <= '0;
            pdig_q  <= 2'b00;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            w_q     <= w_d;
            xq_q    <= xq_d;
            xm_q    <= xm_d;
            yq_q    <= yq_d;
            ym_q    <= ym_d;
            pdig_q  <= pdig_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert ((w_q > NONE) && (w_q < ONE));
        end
    end

    assign in_ready    = (state_q == S_RUN);
    assign busy        = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign p_d         = pdig_q;
    assign out_valid   = vld_q;
    assign out_last    = last_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_r2_online_mult_seq.sv
// Directed bench for r2_online_mult_seq: a driver feeds digit-serial operands and pushes
// hand-computed products; a monitor rebuilds each emitted product and compares.
module tb_r2_online_mult_seq;

    localparam int W = 8;

    // Handshake: a digit pair moves on a rising edge where in_valid && in_ready;
    // p_d is meaningful only in cycles where out_valid is high.
    logic       clk = 1'b0;
    logic       rst, start, in_valid;
    logic [1:0] x_d, y_d, p_d, dbg_state;
    logic       in_ready, out_valid, out_last, busy, err;

    r2_online_mult_seq #(.WIDTH(W), .DELTA(3), .GUARD(2)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .x_d(x_d), .y_d(y_d), .in_ready(in_ready), .p_d(p_d),
        .out_valid(out_valid), .out_last(out_last), .busy(busy),
        .err(err), .dbg_state_o(dbg_state)
    );

    // Clock/reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    // Scoreboard: expected product in units of 2^-16 plus per-product flags.
    logic signed [31:0] exp_q[$];
    bit exp_err_q[$];
    bit exp_exact_q[$];
    bit exp_nogap_q[$];
    int start_cyc = 0;

    // Monitor
    int     cnt = 0;
    longint acc = 0;
    longint diff;
    bit     stall_prev = 0, busy_prev = 0, busy_pending = 0;

    always @(negedge clk) begin
        if (rst) begin
            cnt = 0; acc = 0; stall_prev = 0; busy_prev = 0; busy_pending = 0;
        end else begin
            if (stall_prev) check(!out_valid, "stall_no_output", out_valid, 0);
            if (busy_prev && !busy && busy_pending) begin
                check(cyc - start_cyc + 1 == 13, "start_to_idle_cycles", cyc - start_cyc + 1, 13);
                busy_pending = 0;
            end
            if (out_valid) begin
                check(exp_q.size() > 0, "output_expected", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    check(p_d != 2'b10, "digit_encoding", p_d, 0);
                    if (cnt == 0 && exp_nogap_q[0])
                        check(cyc - start_cyc + 1 == 5, "first_digit_latency", cyc - start_cyc + 1, 5);
                    if (exp_exact_q[0]) check(p_d == 2'b00, "zero_digit", p_d, 0);
                    acc = acc * 2 + ((p_d == 2'b01) ? 1 : ((p_d == 2'b11) ? -1 : 0));
                    cnt++;
                    if (out_last) begin
                        check(cnt == W, "digit_count", cnt, W);
                        diff = acc * 256 - exp_q[0];
                        check(diff <= 256 && diff >= -256, "product_value", acc * 256, exp_q[0]);
                        check(err == exp_err_q[0], "err_flag", err, exp_err_q[0]);
                        busy_pending = exp_nogap_q[0];
                        void'(exp_q.pop_front());
                        void'(exp_err_q.pop_front());
                        void'(exp_exact_q.pop_front());
                        void'(exp_nogap_q.pop_front());
                        cnt = 0;
                        acc = 0;
                    end else begin
                        check(cnt < W, "out_last_on_final_digit", cnt, W - 1);
                    end
                end
            end
            stall_prev = in_ready && !in_valid;
            busy_prev  = busy;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_product(input logic [15:0] xv, input logic [15:0] yv, input int expv,
                               input bit exp_err, input bit exact, input bit gaps,
                               input bit glitch, input bit late_start);
        logic [1:0] xd;
        int n;
        exp_q.push_back(expv);
        exp_err_q.push_back(exp_err);
        exp_exact_q.push_back(exact);
        exp_nogap_q.push_back(!gaps && !glitch);
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        for (int i = 1; i <= W; i++) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                    in_valid = 1'b0;
                    tick();
                end
            end
            if (glitch && i == 4) begin
                in_valid = 1'b0;
                start = 1'b1;
                tick();
                start = 1'b0;
                check(in_ready == 1'b1, "start_ignored_in_run", in_ready, 1);
            end
            xd = xv[2*(W-i) +: 2];
            in_valid = 1'b1;
            x_d = xd;
            y_d = yv[2*(W-i) +: 2];
            tick();
            if (xd == 2'b10) check(err == 1'b1, "err_next_cycle", err, 1);
        end
        in_valid = 1'b0;
        x_d = 2'b00;
        y_d = 2'b00;
        if (late_start) begin
            n = 0;
            while (!out_last && n < 40) begin
                tick();
                n++;
            end
            check(out_last == 1'b1, "final_cycle_reached", out_last, 1);
            start = 1'b1;
            tick();
            start = 1'b0;
            check(busy == 1'b0, "start_ignored_final_cycle", busy, 0);
        end
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        check(busy == 1'b0, "product_done", busy, 0);
        tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check(p_d == 2'b00, {tag, "_p_d"}, p_d, 0);
        check(out_valid == 1'b0, {tag, "_out_valid"}, out_valid, 0);
        check(out_last == 1'b0, {tag, "_out_last"}, out_last, 0);
        check(in_ready == 1'b0, {tag, "_in_ready"}, in_ready, 0);
        check(busy == 1'b0, {tag, "_busy"}, busy, 0);
        check(err == 1'b0, {tag, "_err"}, err, 0);
    endtask

    task automatic reset_mid_product();
        logic [15:0] xv;
        xv = 16'h5840;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            x_d = xv[2*(W-i) +: 2];
            y_d = 2'b01;
            tick();
        end
        check(err == 1'b1, "err_before_reset", err, 1);
        x_d = 2'b01;
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        x_d = 2'b00;
        y_d = 2'b00;
        check_outputs_zero("mid_reset");
        tick();
        check(busy == 1'b0, "reset_beats_start", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        x_d = 2'b00;
        y_d = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // xv/yv: digit 1 in bits [15:14]; 01=+1, 11=-1, 00=0, 10=illegal
        run_product(16'h0000, 16'h0000, 0,      0, 1, 0, 0, 0);
        run_product(16'h4000, 16'h4000, 16384,  0, 0, 0, 0, 0);
        run_product(16'h5555, 16'hFFFF, -65025, 0, 0, 0, 0, 0);
        run_product(16'h5000, 16'hC000, -24576, 0, 0, 1, 1, 0);
        run_product(16'h710D, 16'h1713, 6557,   0, 0, 1, 0, 0);
        run_product(16'hC000, 16'hFFFF, 32640,  0, 0, 0, 0, 1);
        run_product(16'h5840, 16'h4C01, 19400,  1, 0, 0, 0, 0);
        run_product(16'h0001, 16'h0003, -1,     0, 0, 0, 0, 0);
        run_product(16'h5555, 16'hFFFF, -65025, 0, 0, 1, 0, 0);

        reset_mid_product();
        run_product(16'h4000, 16'h4000, 16384,  0, 0, 0, 0, 0);

        repeat (5) tick();
        check(exp_q.size() == 0, "pending_products", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/r2_online_mult_seq.md
R2_ONLINE_MULT_SEQ -- requirements
Module: r2_online_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of radix-2 signed digits per operand and per product (legal 4..32).
REQ-002 SHALL have parameter DELTA, default 3: online delay in digits (legal 3..4).
REQ-003 SHALL have parameter GUARD, default 2: extra fractional guard bits in the residual register.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle pulse that begins a new product; honoured only in IDLE.
REQ-007 in_valid  input  1  x_d/y_d carry the next MSDF digit pair.
REQ-008 x_d, y_d  input  2 each  signed digits: 2'b01=+1, 2'b11=-1, 2'b00=0, 2'b10 illegal.
REQ-009 in_ready  output  1  high in RUN; a digit pair is consumed when in_valid && in_ready.
REQ-010 p_d  output  2  product digit, same encoding; never 2'b10.
REQ-011 out_valid  output  1  p_d valid this cycle.
REQ-012 out_last  output  1  qualifies p_d as digit p_WIDTH.
REQ-013 busy  output  1  high in RUN or FLUSH.
REQ-014 err  output  1  sticky illegal-digit flag; cleared by start or rst.

Function
REQ-015 SHALL implement FSM IDLE -> RUN (start) -> FLUSH (after WIDTH digit pairs consumed) -> IDLE (after p_WIDTH emitted).
REQ-016 Step counter s: 1..WIDTH+DELTA; advances once per consumed pair in RUN, once per cycle in FLUSH.
REQ-017 Step s uses x_s, y_s; for s>WIDTH both digits are zero, generated internally; in_valid ignored in FLUSH.
REQ-018 in_valid low in RUN SHALL stall: no state change, out_valid low.
REQ-019 Operands X, Y SHALL be held as two's-complement partial values via on-the-fly conversion, WIDTH+1 bits.
REQ-020 Residual w SHALL be two's complement, 2 integer bits + WIDTH+DELTA+GUARD fractional bits; reset/start value 0.
REQ-021 Each step: v = 2w + (X_{s-1}*y_s + X_s... specifically X_{s-1}*y_s + Y_s*x_s) * 2^-DELTA, X/Y updated with x_s, y_s before the next step.
REQ-022 For s<=DELTA: p not selected, w <- v.
REQ-023 For s>DELTA: p = +1 if v >= 1/2, -1 if v < -1/2, else 0; w <- v - p; p registered and emitted as p_{s-DELTA}.
REQ-024 out_valid SHALL rise the cycle after step s=DELTA+1; exactly WIDTH digits emitted per product, out_last with the last.
REQ-025 |w| SHALL stay below 1 at all times (assertion).
REQ-026 Emitted value P = sum p_j*2^-j SHALL satisfy |P - X*Y| <= 2^-WIDTH for all legal operands.
REQ-027 start outside IDLE SHALL be ignored; start coincident with final output cycle ignored (IDLE not yet reached).
REQ-028 Illegal digit consumed SHALL set err next cycle and be treated as 0; computation continues.
REQ-029 Minimum latency start -> first p: DELTA+2 cycles with continuous in_valid; start -> IDLE: WIDTH+DELTA+2 cycles.

Reset
REQ-030 rst SHALL, at any time including mid-product, force IDLE, s=0, w=X=Y=0, p_d=0, out_valid=out_last=in_ready=busy=err=0.
REQ-031 rst has priority over start and in_valid in the same cycle.

Verification
REQ-032 WIDTH=8, x=y=all zeros, in_valid constant -> 8 digits all 00, out_last on 8th, busy low 13 cycles after start.
REQ-033 x=y=0.5 (d1=+1, rest 0) -> P=0.25 within 2^-8.
REQ-034 x=all +1 (1-2^-8), y=all -1 -> P within 2^-8 of -(1-2^-8)^2; no 2'b10 output.
REQ-035 Random in_valid gaps (≈50%), 1000 random operand pairs -> REQ-026 holds, digit count 8, no output during stalls.
REQ-036 rst asserted at step 5 -> all outputs 0 next cycle; subsequent start gives correct product.
REQ-037 x_3=2'b10 -> err high from next cycle until next start; P equals product with x_3=0.
